// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: access-size encodings, the
//   FSM state enum and a helper that classifies illegal size/alignment pairs.
//   No ports (package).
package lsu_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // True when the size is reserved or the byte offset does not match the
    // natural alignment of the access.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Purely combinational lane steering for the load/store unit.
//   Ports:
//     size        in   2   access size (lsu_pkg SZ_*)
//     is_unsigned in   1   loads: 1 = zero-extend, 0 = sign-extend
//     offset      in   2   byte offset within the word (addr[1:0])
//     load_word   in   32  word read from data memory
//     old_word    in   32  word captured for read-modify-write
//     store_data  in   32  store data, right-justified
//     load_data   out  32  selected lane, extended to 32 bits
//     merge_data  out  32  old_word with the addressed lane replaced
//   Lanes are little-endian: offset 0 is bits [7:0].
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};
    assign byte_lane  = load_word >> byte_shift;
    assign half_lane  = load_word >> half_shift;

    always_comb begin
        load_data = load_word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane[7:0]};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane[15:0]};
            default: load_data = load_word;
        endcase
    end

    // Store merge: clear the addressed lane in the old word, then OR in the
    // new data shifted to that lane. Upper bits of store_data are ignored.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = store_data;
        case (size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF << byte_shift;
                lane_data = {24'h0, store_data[7:0]} << byte_shift;
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF << half_shift;
                lane_data = {16'h0, store_data[15:0]} << half_shift;
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = store_data;
            end
        endcase
        merge_data = (old_word & ~lane_mask) | lane_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the MEM pipeline stage to a word-addressed data memory. Handles
//   byte/half/word loads and stores, load extension, read-modify-write for
//   sub-word stores and misalignment / reserved-size errors. One request at
//   a time.
//   Optional feature macro: LSU_RANGE_CHECK_EN -- when defined, word index
//   addr[31:2] >= MEM_WORDS is reported as an error without a memory access.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req_valid/req_ready request handshake
//     req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//     resp_valid          one-cycle completion pulse
//     resp_err, resp_rdata completion status/data, held until next response
//     mem_addr, mem_wdata, mem_we, mem_re, mem_rdata  data memory interface
//     state_dbg           current FSM state (lsu_state_t encoding)
//   Handshake: a request is accepted on a rising edge where req_valid and
//   req_ready are both high; req_ready is high only in IDLE, so the request
//   fields are sampled exactly once, on that edge. resp_valid is a single
//   cycle pulse with no back-pressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state_dbg
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    lsu_state_t  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        range_err;
    logic        req_bad;
    logic        word_store;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign range_err  = RANGE_CHECK && (req_addr[31:2] >= 30'(MEM_WORDS));
    assign req_bad    = bad_access(req_size, req_addr[1:0]) || range_err;
    assign word_store = we_q && (size_q == SZ_WORD);

    assign req_ready  = (state == ST_IDLE);
    assign state_dbg  = state;
    assign mem_addr   = {addr_q[31:2], 2'b00};

    // Strobes are gated by rst so a reset landing in MERGE cannot write.
    assign mem_re     = !rst && (state == ST_ACCESS);
    assign mem_we     = !rst && (((state == ST_ACCESS) && word_store) || (state == ST_MERGE));
    assign mem_wdata  = (state == ST_MERGE) ? merge_data : wdata_q;

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (addr_q[1:0]),
        .load_word   (mem_rdata),
        .old_word    (merge_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            // Rejected requests skip memory and respond next cycle.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= ST_RESP;
                    end else if (size_q == SZ_WORD) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        state      <= ST_RESP;
                    end else begin
                        // Sub-word store: keep the old word for the merge cycle.
                        merge_q <= mem_rdata;
                        state   <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. A word-addressed memory model sits on
//   the memory port. Each issued request pushes its expected response
//   {accept cycle, latency, err, rdata} into exp_q; a monitor pops and
//   compares whenever resp_valid is seen.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int W = 67;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [1:0]  state_dbg;

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .state_dbg    (state_dbg)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:1023];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h8899_AABB;
            mem[2] <= 32'h1122_3344;
        end else if (mem_we && (mem_addr[31:12] == 20'h0)) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr[31:12] == 20'h0) ? mem[mem_addr[11:2]] : 32'h0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int last_resp_cyc = -10;
    int we_cnt = 0;
    int re_cnt = 0;
    int last_we_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
    endtask

    // Response monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp_err",   {31'h0, resp_err}, {31'h0, e[32]});
                check("resp_rdata", resp_rdata, e[31:0]);
                check("latency",    32'(cyc - int'(e[66:35])), {30'h0, e[34:33]});
                last_resp_cyc = cyc;
            end
        end
    end

    // Memory-port activity monitor
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (mem_re) re_cnt++;
        if (mem_we || mem_re) check("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int lat, input bit track, input bit b2b, output int acc);
        int t;
        logic [31:0] acc_v;
        logic [1:0]  lat_v;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            fail_now("accept");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (b2b) check("b2b_accept", 32'(acc), 32'(last_resp_cyc + 1));
        if (track) begin
            acc_v = 32'(acc);
            lat_v = 2'(lat);
            exp_q.push_back({acc_v, lat_v, exp_err, exp_rdata});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_wait");
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int we0;
        int re0;

        rst          = 1'b1;
        mem_init     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check("rst_mem_re",     {31'h0, mem_re},     32'h0);
        rst = 1'b0;

        // Loads from mem[1] = 8899AABB, back to back
        issue(1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, 1'b0, 32'hFFFF_FFAA, 2, 1, 0, acc);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0, 1'b0, 32'h0000_00AA, 2, 1, 1, acc);
        issue(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, 1'b0, 32'h0000_8899, 2, 1, 1, acc);
        issue(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 1'b0, 32'hFFFF_8899, 2, 1, 1, acc);
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'h8899_AABB, 2, 1, 1, acc);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h4, 32'h0, 1'b0, 32'hFFFF_FFBB, 2, 1, 1, acc);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h7, 32'h0, 1'b0, 32'h0000_0088, 2, 1, 1, acc);
        issue(1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0, 1'b0, 32'hFFFF_AABB, 2, 1, 1, acc);
        wait_done();

        // Byte store with read-modify-write
        we0 = we_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h7, 32'h0000_00CC, 1'b0, 32'h0, 3, 1, 0, acc);
        wait_done();
        check("sb_mem1",     mem[1], 32'hCC99_AABB);
        check("sb_we_count", 32'(we_cnt - we0), 32'h1);
        check("sb_we_cycle", 32'(last_we_cyc), 32'(acc + 2));
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hCC99_AABB, 2, 1, 1, acc);

        // Half stores into mem[2] = 11223344, word store, byte store with junk upper bits
        issue(1'b1, SZ_HALF, 1'b0, 32'h8,  32'hFFFF_1234, 1'b0, 32'h0, 3, 1, 1, acc);
        issue(1'b1, SZ_HALF, 1'b0, 32'hA,  32'h0000_BEEF, 1'b0, 32'h0, 3, 1, 1, acc);
        issue(1'b1, SZ_WORD, 1'b0, 32'hC,  32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 1, acc);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'hFFFF_FF5A, 1'b0, 32'h0, 3, 1, 1, acc);
        wait_done();
        check("sh_mem2", mem[2], 32'hBEEF_1234);
        check("sw_mem3", mem[3], 32'hDEAD_BEEF);
        check("sb_mem4", mem[4], 32'h0000_005A);

        // Error cases: no memory activity at all
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hCC99_AABB, 2, 1, 1, acc);
        wait_done();
        we0 = we_cnt;
        re0 = re_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0,          1'b1, 32'h0, 1, 1, 0, acc);
        issue(1'b0, SZ_HALF, 1'b1, 32'h3, 32'h0,          1'b1, 32'h0, 1, 1, 1, acc);
        issue(1'b1, SZ_WORD, 1'b0, 32'h1, 32'h1111_1111,  1'b1, 32'h0, 1, 1, 1, acc);
        issue(1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0,          1'b1, 32'h0, 1, 1, 1, acc);
        issue(1'b1, SZ_HALF, 1'b0, 32'h5, 32'h2222_2222,  1'b1, 32'h0, 1, 1, 1, acc);
        wait_done();
        check("err_we_count", 32'(we_cnt - we0), 32'h0);
        check("err_re_count", 32'(re_cnt - re0), 32'h0);
        check("err_mem1",     mem[1], 32'hCC99_AABB);

        // Reset landing in MERGE of a half store
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hCC99_AABB, 2, 1, 0, acc);
        wait_done();
        we0 = we_cnt;
        issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_5555, 1'b0, 32'h0, 3, 0, 0, acc);
        @(posedge clk);
        #1;
        check("pre_rst_in_merge", {30'h0, state_dbg}, {30'h0, ST_MERGE});
        rst = 1'b1;
        #1;
        check("rst_merge_we_gated", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("post_rst_resp_rdata", resp_rdata,          32'h0);
        check("post_rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("post_rst_mem4",       mem[4],              32'h0000_005A);
        check("post_rst_we_count",   32'(we_cnt - we0),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Out-of-range word index (0x1000 >> 2 = 1024)
`ifdef LSU_RANGE_CHECK_EN
        issue(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1, 1, 0, acc);
`else
        issue(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0, 2, 1, 0, acc);
`endif
        wait_done();
        issue(1'b0, SZ_BYTE, 1'b0, 32'hE, 32'h0, 1'b0, 32'hFFFF_FFAD, 2, 1, 1, acc);
        wait_done();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
